// File: rtl/aes_selftest_sequencer_if.sv
// ---------------------------------------------------------------------------
// aes_selftest_sequencer_if
//   Bundles the two buses the self-test sequencer sits between:
//   the synchronous vector ROM and the AES-128 core.
//
//   Signals
//     rom_addr   vector index presented to the ROM
//     rom_key    key read from ROM (one cycle after rom_addr)
//     rom_pt     plaintext read from ROM (same timing)
//     rom_ct     expected ciphertext read from ROM (same timing)
//     aes_key    key driven to the core
//     aes_din    plaintext driven to the core
//     aes_start  single-cycle start pulse to the core
//     aes_busy   core busy
//     aes_done   single-cycle pulse, aes_dout valid
//     aes_dout   ciphertext returned by the core
//
//   Modports
//     master  sequencer side (drives ROM address and core inputs)
//     slave   ROM + core side
// ---------------------------------------------------------------------------
interface aes_selftest_sequencer_if #(
    parameter int AW = 8
);
    logic [AW-1:0] rom_addr;
    logic [127:0]  rom_key;
    logic [127:0]  rom_pt;
    logic [127:0]  rom_ct;
    logic [127:0]  aes_key;
    logic [127:0]  aes_din;
    logic          aes_start;
    logic          aes_busy;
    logic          aes_done;
    logic [127:0]  aes_dout;

    modport master (
        output rom_addr, aes_key, aes_din, aes_start,
        input  rom_key, rom_pt, rom_ct, aes_busy, aes_done, aes_dout
    );

    modport slave (
        input  rom_addr, aes_key, aes_din, aes_start,
        output rom_key, rom_pt, rom_ct, aes_busy, aes_done, aes_dout
    );
endinterface

// File: rtl/aes_selftest_sequencer.sv
// ---------------------------------------------------------------------------
// aes_selftest_sequencer
//   Walks a vector ROM and runs each entry through the AES-128 core:
//   fetch key / plaintext / expected ciphertext, fire one encryption,
//   compare the result and keep running totals. Used for on-chip,
//   software-free verification of the core.
//
//   Ports
//     clk       clock
//     rst_n     asynchronous reset, active low
//     work      run enable (level); a vector in flight always completes
//     bus       master side of aes_selftest_sequencer_if (ROM + core)
//     total     vectors scored (saturating)
//     correct   vectors whose result matched (saturating, <= total)
//     err_flag  sticky: any mismatch or timeout since reset
//     running   high in every state except IDLE
//
//   Per-vector flow: IDLE -> FETCH -> LATCH -> START -> WAIT -> CHECK,
//   giving a START-to-START period of core latency + 4 under steady work.
// ---------------------------------------------------------------------------
module aes_selftest_sequencer #(
    parameter int N_VEC   = 256,
    parameter int AW      = 8,
    parameter int CW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      work,
    aes_selftest_sequencer_if.master  bus,
    output logic [CW-1:0]             total,
    output logic [CW-1:0]             correct,
    output logic                      err_flag,
    output logic                      running
);

    // Timer must be able to hold TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4,
        CHECK = 3'd5
    } state_t;

    state_t        state_q, state_d;

    logic [AW-1:0] addr_q;
    logic [127:0]  key_q;
    logic [127:0]  din_q;
    logic [127:0]  exp_q;
    logic [127:0]  dout_q;
    logic [TW-1:0] timer_q;
    logic          tmo_q;
    logic [CW-1:0] total_q;
    logic [CW-1:0] correct_q;
    logic          err_q;

    logic          timer_last;
    logic          vec_pass;

    // The timer runs 0..TIMEOUT-1 across WAIT, so the core gets TIMEOUT
    // WAIT cycles; a done arriving in the last of them still counts.
    assign timer_last = (timer_q == TW'(TIMEOUT - 1));
    assign vec_pass   = !tmo_q && (dout_q == exp_q);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (work && !bus.aes_busy) state_d = FETCH;
            FETCH: state_d = LATCH;
            LATCH: state_d = START;
            START: state_d = WAIT;
            WAIT: begin
                if (bus.aes_done || timer_last) state_d = CHECK;
            end
            CHECK: state_d = work ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: operand latch, result capture, scoring, address walk
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            key_q     <= '0;
            din_q     <= '0;
            exp_q     <= '0;
            dout_q    <= '0;
            timer_q   <= '0;
            tmo_q     <= 1'b0;
            total_q   <= '0;
            correct_q <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                LATCH: begin
                    // Operands stay put until the next LATCH so the core
                    // sees stable inputs for the whole encryption.
                    key_q <= bus.rom_key;
                    din_q <= bus.rom_pt;
                    exp_q <= bus.rom_ct;
                end
                START: begin
                    timer_q <= '0;
                    tmo_q   <= 1'b0;
                end
                WAIT: begin
                    // done takes priority over expiry in the same cycle.
                    if (bus.aes_done) begin
                        dout_q <= bus.aes_dout;
                    end else if (timer_last) begin
                        tmo_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                CHECK: begin
                    if (total_q != {CW{1'b1}}) total_q <= total_q + CW'(1);
                    // correct only moves alongside total, so it can never
                    // overtake it, saturated or not.
                    if (vec_pass) begin
                        if (correct_q != {CW{1'b1}}) correct_q <= correct_q + CW'(1);
                    end else begin
                        err_q <= 1'b1;
                    end
                    addr_q <= (addr_q == AW'(N_VEC - 1)) ? '0 : addr_q + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // aes_start decodes the state register directly so an asynchronous
    // reset removes it immediately.
    assign bus.aes_start = (state_q == START);
    assign bus.rom_addr  = addr_q;
    assign bus.aes_key   = key_q;
    assign bus.aes_din   = din_q;

    assign total    = total_q;
    assign correct  = correct_q;
    assign err_flag = err_q;
    assign running  = (state_q != IDLE);

endmodule

// File: tb/tb_aes_selftest_sequencer.sv
module tb_aes_selftest_sequencer;

    localparam int N_VEC   = 4;
    localparam int AW      = 2;
    localparam int CW      = 4;
    localparam int TIMEOUT = 64;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          work  = 1'b0;
    logic [CW-1:0] total;
    logic [CW-1:0] correct;
    logic          err_flag;
    logic          running;

    aes_selftest_sequencer_if #(.AW(AW)) bus();

    aes_selftest_sequencer #(
        .N_VEC(N_VEC), .AW(AW), .CW(CW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .work    (work),
        .bus     (bus),
        .total   (total),
        .correct (correct),
        .err_flag(err_flag),
        .running (running)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Stand-in cipher: any fixed mixing of key and plaintext will do.
    function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] p);
        return {k[63:0], k[127:64]} ^ p ^ {4{32'h5A3C_96E1}};
    endfunction

    // ---------------- vector ROM model (1-cycle read latency) --------------
    logic [127:0] key_tbl [N_VEC];
    logic [127:0] pt_tbl  [N_VEC];
    logic [127:0] ct_tbl  [N_VEC];
    int           bad_idx = -1;

    always @(posedge clk) begin
        bus.rom_key <= key_tbl[bus.rom_addr];
        bus.rom_pt  <= pt_tbl[bus.rom_addr];
        bus.rom_ct  <= ct_tbl[bus.rom_addr] ^
                       ((int'(bus.rom_addr) == bad_idx) ? 128'h1 : 128'h0);
    end

    // ---------------- AES core model: done L cycles after start ------------
    int   core_lat  = 10;
    bit   core_dead = 1'b0;
    logic spur      = 1'b0;
    logic done_r;
    int   cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= 0;
            done_r       <= 1'b0;
            bus.aes_busy <= 1'b0;
            bus.aes_dout <= '0;
        end else begin
            done_r <= 1'b0;
            if (bus.aes_start) begin
                cnt          <= core_dead ? 0 : core_lat - 1;
                bus.aes_busy <= 1'b1;
                bus.aes_dout <= cipher(bus.aes_key, bus.aes_din);
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    done_r       <= 1'b1;
                    bus.aes_busy <= 1'b0;
                end
            end
        end
    end

    assign bus.aes_done = done_r | spur;

    // ---------------- monitor: start times and addresses -------------------
    int cyc = 0;
    int nstart;
    int st_cyc  [32];
    int st_addr [32];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nstart <= 0;
        end else if (bus.aes_start && nstart < 32) begin
            st_cyc[nstart]  <= cyc;
            st_addr[nstart] <= int'(bus.rom_addr);
            nstart          <= nstart + 1;
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        fails++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic do_reset();
        work  = 1'b0;
        spur  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k = 0;
        while (nstart < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (nstart < n) timeout_fail("wait_starts");
    endtask

    task automatic wait_total(input int n, input int budget);
        int k = 0;
        while (int'(total) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (int'(total) < n) timeout_fail("wait_total");
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (running && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (running) timeout_fail("wait_idle");
    endtask

    typedef struct {
        string name;
        int    lat;
        int    nvec;
        int    bad;
        int    exp_total;
        int    exp_correct;
        int    exp_err;
        int    exp_addr;
    } scen_t;

    scen_t tbl [5];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_now;
        int k;

        for (int i = 0; i < N_VEC; i++) begin
            key_tbl[i] = {4{32'h1111_0000 + 32'(i)}};
            pt_tbl[i]  = {4{32'hC0DE_0000 ^ (32'(i) * 32'h0101)}};
            ct_tbl[i]  = cipher(key_tbl[i], pt_tbl[i]);
        end

        //          name        lat nvec bad tot cor err addr
        tbl[0] = '{"good4",     10, 4,  -1, 4,  4,  0,  0};
        tbl[1] = '{"wrap6",     10, 6,  -1, 6,  6,  0,  2};
        tbl[2] = '{"bad2",      10, 4,   2, 4,  3,  1,  0};
        tbl[3] = '{"bad0x2",     3, 5,   0, 5,  3,  1,  1};
        tbl[4] = '{"done_last", 64, 2,  -1, 2,  2,  0,  2};

        // ---- reset state ----
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_total",    int'(total), 0);
        chk("rst_correct",  int'(correct), 0);
        chk("rst_err",      int'(err_flag), 0);
        chk("rst_running",  int'(running), 0);
        chk("rst_addr",     int'(bus.rom_addr), 0);
        chk("rst_start",    int'(bus.aes_start), 0);
        chk128("rst_key",   bus.aes_key, '0);
        chk128("rst_din",   bus.aes_din, '0);

        // ---- table-driven scenarios ----
        for (int r = 0; r < 5; r++) begin
            core_lat = tbl[r].lat;
            bad_idx  = tbl[r].bad;
            do_reset();
            work = 1'b1;
            wait_starts(tbl[r].nvec, (tbl[r].lat + 4) * tbl[r].nvec + 40);
            work = 1'b0;
            wait_idle(tbl[r].lat + 80);
            chk({tbl[r].name, "_total"},   int'(total), tbl[r].exp_total);
            chk({tbl[r].name, "_correct"}, int'(correct), tbl[r].exp_correct);
            chk({tbl[r].name, "_err"},     int'(err_flag), tbl[r].exp_err);
            chk({tbl[r].name, "_addr"},    int'(bus.rom_addr), tbl[r].exp_addr);
        end
        bad_idx = -1;

        // ---- start period (L+4) and address walk with wrap ----
        core_lat = 10;
        do_reset();
        work = 1'b1;
        wait_starts(6, 200);
        work = 1'b0;
        wait_idle(100);
        for (int i = 1; i < 6; i++) chk("start_period", st_cyc[i] - st_cyc[i-1], 14);
        for (int i = 0; i < 6; i++) chk("start_addr", st_addr[i], i % N_VEC);

        // ---- err_flag rises exactly when vector 2 is scored ----
        bad_idx = 2;
        do_reset();
        work = 1'b1;
        wait_total(2, 100);
        chk("err_before_v2", int'(err_flag), 0);
        wait_total(3, 100);
        chk("err_after_v2", int'(err_flag), 1);
        chk("correct_after_v2", int'(correct), 2);
        work = 1'b0;
        wait_idle(100);
        bad_idx = -1;

        // ---- core never answers: timeout scoring ----
        core_dead = 1'b1;
        do_reset();
        work = 1'b1;
        wait_starts(1, 20);
        wait_total(1, 120);
        t_now = cyc;
        // CHECK follows TIMEOUT WAIT cycles; total is visible one edge later.
        chk("timeout_latency", t_now - st_cyc[0], TIMEOUT + 2);
        chk("timeout_total", int'(total), 1);
        chk("timeout_correct", int'(correct), 0);
        chk("timeout_err", int'(err_flag), 1);
        wait_starts(2, 20);
        chk("timeout_next_addr", st_addr[1], 1);
        core_dead = 1'b0;
        do_reset();

        // ---- drop work during WAIT, spurious done, resume ----
        core_lat = 10;
        do_reset();
        work = 1'b1;
        wait_starts(1, 20);
        repeat (3) @(negedge clk);
        work = 1'b0;
        wait_idle(60);
        chk("drop_total", int'(total), 1);
        chk("drop_correct", int'(correct), 1);
        chk("drop_running", int'(running), 0);
        chk("drop_addr", int'(bus.rom_addr), 1);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (4) @(negedge clk);
        chk("spur_total", int'(total), 1);
        chk("spur_nstart", nstart, 1);
        work = 1'b1;
        wait_starts(2, 40);
        chk("resume_addr", st_addr[1], 1);
        chk("resume_total_kept", int'(total), 1);

        // ---- async reset during WAIT: outputs clear immediately ----
        bad_idx = 0;
        do_reset();
        work = 1'b1;
        wait_starts(2, 60);
        repeat (3) @(negedge clk);
        chk("prerst_total", int'(total), 1);
        chk("prerst_err", int'(err_flag), 1);
        rst_n = 1'b0;
        #1;
        chk("wrst_total", int'(total), 0);
        chk("wrst_correct", int'(correct), 0);
        chk("wrst_err", int'(err_flag), 0);
        chk("wrst_running", int'(running), 0);
        chk("wrst_addr", int'(bus.rom_addr), 0);
        chk128("wrst_key", bus.aes_key, '0);
        work    = 1'b0;
        bad_idx = -1;
        do_reset();

        // ---- async reset during START: pulse drops at once ----
        work = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.aes_start && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!bus.aes_start) timeout_fail("wait_start_cycle");
        rst_n = 1'b0;
        #1;
        chk("srst_start", int'(bus.aes_start), 0);
        chk("srst_running", int'(running), 0);
        work = 1'b0;
        do_reset();

        // ---- saturation with CW=4: 17 vectors, counters stop at 15 ----
        core_lat = 3;
        do_reset();
        work = 1'b1;
        wait_starts(17, 17 * 7 + 40);
        work = 1'b0;
        wait_idle(40);
        chk("sat_total", int'(total), 15);
        chk("sat_correct", int'(correct), 15);
        chk("sat_err", int'(err_flag), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
